// File: rtl/ula_pkg.sv
// Shared opcode constants, FSM state type and flag helpers for the multi-cycle ALU.
package ula_pkg;

   // Opcode class, OP[4:3]
   localparam logic [1:0] CLS_ARITH   = 2'b00;
   localparam logic [1:0] CLS_LOGIC   = 2'b01;
   localparam logic [1:0] CLS_SHIFT   = 2'b10;
   localparam logic [1:0] CLS_ILLEGAL = 2'b11;

   // Arithmetic operations, OP[2:0]
   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_INC = 3'd2;
   localparam logic [2:0] OP_DEC = 3'd3;
   localparam logic [2:0] OP_ADC = 3'd4;

   // Logic operations, OP[2:0]
   localparam logic [2:0] OP_AND   = 3'd0;
   localparam logic [2:0] OP_OR    = 3'd1;
   localparam logic [2:0] OP_XOR   = 3'd2;
   localparam logic [2:0] OP_NAND  = 3'd3;
   localparam logic [2:0] OP_NOR   = 3'd4;
   localparam logic [2:0] OP_NOT   = 3'd5;
   localparam logic [2:0] OP_PASSA = 3'd6;
   localparam logic [2:0] OP_PASSB = 3'd7;

   // Shift operations, OP[2:0]; codes 1xx are illegal
   localparam logic [2:0] OP_SLL = 3'd0;
   localparam logic [2:0] OP_SRL = 3'd1;
   localparam logic [2:0] OP_SRA = 3'd2;
   localparam logic [2:0] OP_ROL = 3'd3;

   typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

   // Signed overflow from operand and result sign bits
   function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
      return (sa == sb) && (sr != sa);
   endfunction

   function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
      return (sa != sb) && (sr != sa);
   endfunction

endpackage

// File: rtl/ula_core.sv
// Combinational evaluation of single-cycle arithmetic/logic ops and opcode legality.
// Legal shift opcodes report no error here; the iteration itself lives in ula_mc.
module ula_core
   import ula_pkg::*;
#(
   parameter int BITS = 16
) (
   input  logic [BITS-1:0] a,
   input  logic [BITS-1:0] b,
   input  logic [4:0]      op,
   input  logic            cf,
   output logic [BITS-1:0] res,
   output logic            ovf,
   output logic            carry,
   output logic            err
);

   localparam logic [BITS-1:0] ONE = {{(BITS-1){1'b0}}, 1'b1};

   logic [BITS:0] sum;

   // Decode class and operation; illegal codes leave res at zero with err set
   always_comb begin
      res   = '0;
      ovf   = 1'b0;
      carry = 1'b0;
      err   = 1'b0;
      sum   = '0;
      case (op[4:3])
         CLS_ARITH: begin
            case (op[2:0])
               OP_ADD: begin
                  sum   = {1'b0, a} + {1'b0, b};
                  res   = sum[BITS-1:0];
                  carry = sum[BITS];
                  ovf   = add_ovf(a[BITS-1], b[BITS-1], res[BITS-1]);
               end
               OP_SUB: begin
                  res   = a - b;
                  carry = (a < b);
                  ovf   = sub_ovf(a[BITS-1], b[BITS-1], res[BITS-1]);
               end
               OP_INC: begin
                  sum   = {1'b0, a} + {1'b0, ONE};
                  res   = sum[BITS-1:0];
                  carry = sum[BITS];
                  ovf   = add_ovf(a[BITS-1], 1'b0, res[BITS-1]);
               end
               OP_DEC: begin
                  res   = a - ONE;
                  carry = (a < ONE);
                  ovf   = sub_ovf(a[BITS-1], 1'b0, res[BITS-1]);
               end
               OP_ADC: begin
                  sum   = {1'b0, a} + {1'b0, b} + {{BITS{1'b0}}, cf};
                  res   = sum[BITS-1:0];
                  carry = sum[BITS];
                  ovf   = add_ovf(a[BITS-1], b[BITS-1], res[BITS-1]);
               end
               default: err = 1'b1;
            endcase
         end
         CLS_LOGIC: begin
            case (op[2:0])
               OP_AND:   res = a & b;
               OP_OR:    res = a | b;
               OP_XOR:   res = a ^ b;
               OP_NAND:  res = ~(a & b);
               OP_NOR:   res = ~(a | b);
               OP_NOT:   res = ~a;
               OP_PASSA: res = a;
               default:  res = b;
            endcase
         end
         CLS_SHIFT: err = op[2];
         default:   err = 1'b1;
      endcase
   end

endmodule

// File: rtl/ula_mc.sv
// Multi-cycle ALU: operand/result handshake, bit-serial shifter, flag and carry registers.
module ula_mc
   import ula_pkg::*;
#(
   parameter int BITS = 16,
   parameter int SHW  = $clog2(BITS)
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [BITS-1:0] A,
   input  logic [BITS-1:0] B,
   input  logic [4:0]      OP,
   input  logic            IN_VALID,
   output logic            IN_READY,
   output logic            OUT_VALID,
   input  logic            OUT_READY,
   output logic [BITS-1:0] RESU,
   output logic            O,
   output logic            C,
   output logic            S,
   output logic            Z,
   output logic            ERR
);

   state_t          state_q, state_d;
   logic [BITS-1:0] sh_q, sh_d;
   logic [SHW-1:0]  cnt_q, cnt_d;
   logic [2:0]      sop_q, sop_d;
   logic [BITS-1:0] resu_q, resu_d;
   logic            o_q, o_d, c_q, c_d, s_q, s_d, z_q, z_d, err_q, err_d;
   logic            cf_q, cf_d;
   logic            upd_q, upd_d;  // held result updates CF on hand-off

   logic            accept, handoff, cf_eff, is_shift;
   logic [SHW-1:0]  amt;
   logic [BITS-1:0] core_res, sh_next, ld_res;
   logic            core_o, core_c, core_err, sh_out;
   logic            ld_en, ld_o, ld_c, ld_err, ld_upd;

   assign IN_READY  = (state_q == IDLE) || ((state_q == HOLD) && OUT_READY);
   assign OUT_VALID = (state_q == HOLD);
   assign accept    = IN_VALID && IN_READY;
   assign handoff   = (state_q == HOLD) && OUT_READY;
   // Forward the carry being handed off so a back-to-back ADDC sees it
   assign cf_eff    = (handoff && upd_q) ? c_q : cf_q;
   assign is_shift  = (OP[4:3] == CLS_SHIFT) && !OP[2];
   assign amt       = B[SHW-1:0];

   assign RESU = resu_q;
   assign O    = o_q;
   assign C    = c_q;
   assign S    = s_q;
   assign Z    = z_q;
   assign ERR  = err_q;

   ula_core #(
      .BITS (BITS)
   ) u_core (
      .a     (A),
      .b     (B),
      .op    (OP),
      .cf    (cf_eff),
      .res   (core_res),
      .ovf   (core_o),
      .carry (core_c),
      .err   (core_err)
   );

   // One-bit shift step of the working value
   always_comb begin
      sh_next = sh_q;
      sh_out  = 1'b0;
      case (sop_q)
         OP_SLL: begin
            sh_out  = sh_q[BITS-1];
            sh_next = {sh_q[BITS-2:0], 1'b0};
         end
         OP_SRL: begin
            sh_out  = sh_q[0];
            sh_next = {1'b0, sh_q[BITS-1:1]};
         end
         OP_SRA: begin
            sh_out  = sh_q[0];
            sh_next = {sh_q[BITS-1], sh_q[BITS-1:1]};
         end
         default: begin
            sh_out  = sh_q[BITS-1];
            sh_next = {sh_q[BITS-2:0], sh_q[BITS-1]};
         end
      endcase
   end

   // Next state, shift iteration and result/flag loading
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      sop_d   = sop_q;
      resu_d  = resu_q;
      o_d     = o_q;
      c_d     = c_q;
      s_d     = s_q;
      z_d     = z_q;
      err_d   = err_q;
      upd_d   = upd_q;
      cf_d    = cf_eff;
      ld_en   = 1'b0;
      ld_res  = '0;
      ld_o    = 1'b0;
      ld_c    = 1'b0;
      ld_err  = 1'b0;
      ld_upd  = 1'b0;

      case (state_q)
         BUSY: begin
            sh_d  = sh_next;
            cnt_d = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
               state_d = HOLD;
               ld_en   = 1'b1;
               ld_res  = sh_next;
               ld_c    = sh_out;
               ld_upd  = 1'b1;
            end
         end
         HOLD: begin
            if (OUT_READY) state_d = IDLE;
         end
         default: ;
      endcase

      if (accept) begin
         if (is_shift && (amt != '0)) begin
            state_d = BUSY;
            sh_d    = A;
            cnt_d   = amt;
            sop_d   = OP[2:0];
         end else begin
            state_d = HOLD;
            ld_en   = 1'b1;
            if (is_shift) begin
               // Zero-length shift passes A through with no carry
               ld_res = A;
               ld_upd = 1'b1;
            end else begin
               ld_res = core_res;
               ld_o   = core_o;
               ld_c   = core_c;
               ld_err = core_err;
               ld_upd = (OP[4:3] == CLS_ARITH) && !core_err;
            end
         end
      end

      if (ld_en) begin
         resu_d = ld_res;
         o_d    = ld_o;
         c_d    = ld_c;
         s_d    = ld_res[BITS-1];
         z_d    = (ld_res == '0);
         err_d  = ld_err;
         upd_d  = ld_upd;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         sh_q    <= '0;
         cnt_q   <= '0;
         sop_q   <= '0;
         resu_q  <= '0;
         o_q     <= 1'b0;
         c_q     <= 1'b0;
         s_q     <= 1'b0;
         z_q     <= 1'b1;
         err_q   <= 1'b0;
         cf_q    <= 1'b0;
         upd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         sop_q   <= sop_d;
         resu_q  <= resu_d;
         o_q     <= o_d;
         c_q     <= c_d;
         s_q     <= s_d;
         z_q     <= z_d;
         err_q   <= err_d;
         cf_q    <= cf_d;
         upd_q   <= upd_d;
      end
   end

endmodule
